trng_postproc: RTL and testbench

Post-processing stage directly downstream of the raw entropy source. Takes the raw one-bit-per-cycle entropy stream and applies von Neumann debiasing and a repetition-count health test. Packs surviving bits MSB-first into bytes, discards a warm-up window, and buffers the bytes in a small FIFO. Consumers read through a valid/ready handshake.

---
 rtl/trng_pkg.sv | 10 +
 rtl/trng_fifo.sv | 52 +++++
 rtl/trng_postproc.sv | 175 +++++++++++++++++
 tb/tb_trng_postproc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared TRNG types and defaults used by the entropy source, post-processing and consumers.
package trng_pkg;

    localparam int unsigned TRNG_BYTE_W          = 8;
    localparam int unsigned TRNG_RCT_LIMIT_DEF   = 16;
    localparam int unsigned TRNG_WARMUP_DEF      = 2;

    typedef logic [TRNG_BYTE_W-1:0] trng_byte_t;

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through synchronous FIFO with flush; push is accepted when full only alongside a pop.
module trng_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LW'(DEPTH));
    assign level     = r_level;
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!n_reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/trng_postproc.sv
// Raw entropy post-processing: repetition-count health test, von Neumann debiasing,
// MSB-first byte packing with a warm-up discard window, and an output FIFO.
module trng_postproc
    import trng_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned RCT_LIMIT    = TRNG_RCT_LIMIT_DEF,
    parameter int unsigned WARMUP_BYTES = TRNG_WARMUP_DEF
) (
    input  logic                               clk,
    input  logic                               n_reset,
    input  logic                               raw_bit,
    input  logic                               raw_valid,
    input  logic                               clear_fail,
    output trng_byte_t                         out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               health_fail,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int unsigned RCT_W  = 8;
    localparam int unsigned WARM_W = 4;
    localparam int unsigned CNT_W  = 3;

    logic [RCT_W-1:0]  r_rct_cnt;
    logic [RCT_W-1:0]  w_rct_next;
    logic              r_prev_bit;
    logic              w_fail_trip;
    logic              w_clear;
    logic              r_health_fail;
    logic              r_overflow;

    logic              r_phase;
    logic              r_pair_bit;
    logic              r_vn_valid;
    logic              r_vn_bit;

    trng_byte_t        r_pack;
    trng_byte_t        w_pack_next;
    logic [CNT_W-1:0]  r_pack_cnt;
    logic [WARM_W-1:0] r_warm;
    trng_byte_t        r_byte;
    logic              r_byte_valid;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;

    // Run length of identical raw bits; a zero count means no reference bit yet.
    always_comb begin
        w_rct_next = r_rct_cnt;
        if (r_rct_cnt == '0 || raw_bit != r_prev_bit) begin
            w_rct_next = RCT_W'(1);
        end else if (r_rct_cnt != '1) begin
            w_rct_next = r_rct_cnt + RCT_W'(1);
        end
    end

    assign w_fail_trip = raw_valid && (w_rct_next == RCT_W'(RCT_LIMIT));
    assign w_clear     = clear_fail && !w_fail_trip;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_rct_cnt  <= '0;
            r_prev_bit <= 1'b0;
        end else begin
            if (raw_valid) r_prev_bit <= raw_bit;
            if (w_clear) begin
                r_rct_cnt <= '0;
            end else if (raw_valid) begin
                r_rct_cnt <= w_rct_next;
            end
        end
    end

    // Sticky status flags; a fail tripping alongside clear_fail takes precedence.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_health_fail <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_fail_trip) begin
                r_health_fail <= 1'b1;
            end else if (clear_fail) begin
                r_health_fail <= 1'b0;
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Debiaser pair state and vn stage; held cleared while the health test is failing.
    always_ff @(posedge clk) begin
        if (!n_reset || w_fail_trip || r_health_fail) begin
            r_phase    <= 1'b0;
            r_pair_bit <= 1'b0;
            r_vn_valid <= 1'b0;
            r_vn_bit   <= 1'b0;
        end else begin
            r_vn_valid <= 1'b0;
            if (raw_valid) begin
                r_phase <= !r_phase;
                if (!r_phase) begin
                    r_pair_bit <= raw_bit;
                end else if (raw_bit != r_pair_bit) begin
                    r_vn_valid <= 1'b1;
                    r_vn_bit   <= r_pair_bit;
                end
            end
        end
    end

    assign w_pack_next = {r_pack[TRNG_BYTE_W-2:0], r_vn_bit};

    // Packer, warm-up discard and byte stage.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_pack       <= '0;
            r_pack_cnt   <= '0;
            r_warm       <= WARM_W'(WARMUP_BYTES);
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else if (w_fail_trip) begin
            r_pack       <= '0;
            r_pack_cnt   <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (r_vn_valid) begin
                r_pack     <= w_pack_next;
                r_pack_cnt <= r_pack_cnt + CNT_W'(1);
                if (r_pack_cnt == CNT_W'(7)) begin
                    if (r_warm != '0) begin
                        r_warm <= r_warm - WARM_W'(1);
                    end else begin
                        r_byte       <= w_pack_next;
                        r_byte_valid <= 1'b1;
                    end
                end
            end
            if (w_clear) r_warm <= WARM_W'(WARMUP_BYTES);
        end
    end

    assign w_pop  = !w_empty && out_ready;
    assign w_drop = r_byte_valid && w_full && !w_pop && !w_fail_trip;

    trng_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRNG_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (w_fail_trip),
        .push    (r_byte_valid),
        .wdata   (r_byte),
        .pop     (w_pop),
        .rdata   (out_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    assign out_valid   = !w_empty;
    assign health_fail = r_health_fail;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_trng_postproc.sv
// Directed bench for trng_postproc: one instance without warm-up, one with the default warm-up.
module tb_trng_postproc;
    import trng_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       clear_fail = 1'b0;
    logic       out_ready = 1'b0;

    trng_byte_t o0_data, o2_data;
    logic       o0_valid, o2_valid;
    logic       o0_hf, o2_hf;
    logic       o0_ov, o2_ov;
    logic [2:0] o0_level, o2_level;

    int n_cmp = 0;
    int n_err = 0;

    trng_postproc #(.FIFO_DEPTH(4), .RCT_LIMIT(16), .WARMUP_BYTES(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .clear_fail(clear_fail), .out_data(o0_data), .out_valid(o0_valid),
        .out_ready(out_ready), .health_fail(o0_hf), .overflow(o0_ov), .fifo_level(o0_level)
    );

    trng_postproc dut2 (
        .clk(clk), .n_reset(n_reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .clear_fail(clear_fail), .out_data(o2_data), .out_valid(o2_valid),
        .out_ready(out_ready), .health_fail(o2_hf), .overflow(o2_ov), .fifo_level(o2_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raw(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        tick();
        raw_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) begin
                raw(1'b1);
                raw(1'b0);
            end else begin
                raw(1'b0);
                raw(1'b1);
            end
        end
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        n_reset = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(o0_valid), 32'd0);
        check("rst_data",  32'(o0_data),  32'h00);
        check("rst_hf",    32'(o0_hf),    32'd0);
        check("rst_ov",    32'(o0_ov),    32'd0);
        check("rst_level", 32'(o0_level), 32'd0);
        n_reset = 1'b1;

        // 0x55 byte and its latency
        send_byte(8'h55);
        check("lat_edgeA",   32'(o0_valid), 32'd0);
        tick();
        check("lat_edgeA1",  32'(o0_valid), 32'd0);
        tick();
        check("lat_edgeA2",  32'(o0_valid), 32'd1);
        check("b55_data",    32'(o0_data),  32'h55);
        check("b55_level",   32'(o0_level), 32'd1);
        check("b55_warm_w2", 32'(o2_valid), 32'd0);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_level", 32'(o0_level), 32'd0);
        check("pop_data",  32'(o0_data),  32'h00);

        // Equal pairs produce nothing and do not trip the health test
        for (int i = 0; i < 20; i++) begin
            raw(1'b0);
            raw(1'b0);
            raw(1'b1);
            raw(1'b1);
        end
        settle();
        check("eq_valid", 32'(o0_valid), 32'd0);
        check("eq_hf0",   32'(o0_hf),    32'd0);
        check("eq_hf2",   32'(o2_hf),    32'd0);

        // Overflow and drain
        do_reset();
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        settle();
        check("ovf_level",  32'(o0_level), 32'd4);
        check("ovf_flag",   32'(o0_ov),    32'd1);
        check("ovf_head",   32'(o0_data),  32'h01);
        check("ovf_level2", 32'(o2_level), 32'd3);
        check("ovf_head2",  32'(o2_data),  32'h03);
        check("ovf_flag2",  32'(o2_ov),    32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_data", 32'(o0_data), 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check("drain_valid", 32'(o0_valid), 32'd0);
        check("drain_level", 32'(o0_level), 32'd0);
        check("drain_ov",    32'(o0_ov),    32'd1);
        pulse_clear();
        check("clr_ov", 32'(o0_ov), 32'd0);

        // Health fail flushes the FIFO, then recovery
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        settle();
        check("hf_pre_level", 32'(o0_level), 32'd3);
        repeat (15) raw(1'b1);
        check("hf_15_flag",  32'(o0_hf),    32'd0);
        check("hf_15_level", 32'(o0_level), 32'd3);
        raw(1'b1);
        check("hf_16_flag",   32'(o0_hf),    32'd1);
        check("hf_16_valid",  32'(o0_valid), 32'd0);
        check("hf_16_level",  32'(o0_level), 32'd0);
        check("hf_16_data",   32'(o0_data),  32'h00);
        check("hf_16_level2", 32'(o2_level), 32'd0);
        send_byte(8'h5A);
        settle();
        check("hf_hold_level", 32'(o0_level), 32'd0);
        check("hf_hold_flag",  32'(o0_hf),    32'd1);
        pulse_clear();
        check("hf_clr0", 32'(o0_hf), 32'd0);
        check("hf_clr2", 32'(o2_hf), 32'd0);
        send_byte(8'hB0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        settle();
        check("rec_level0", 32'(o0_level), 32'd3);
        check("rec_head0",  32'(o0_data),  32'hB0);
        check("rec_level2", 32'(o2_level), 32'd1);
        check("rec_head2",  32'(o2_data),  32'hB2);

        // Warm-up discards the first two bytes
        do_reset();
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        settle();
        check("wu_level2", 32'(o2_level), 32'd1);
        check("wu_head2",  32'(o2_data),  32'hA2);
        check("wu_level0", 32'(o0_level), 32'd3);
        check("wu_head0",  32'(o0_data),  32'hA0);

        // Reset in the middle of a byte
        do_reset();
        repeat (5) begin
            raw(1'b1);
            raw(1'b0);
        end
        tick();
        n_reset = 1'b0;
        tick();
        check("mid_valid", 32'(o2_valid), 32'd0);
        check("mid_data",  32'(o2_data),  32'h00);
        check("mid_level", 32'(o2_level), 32'd0);
        check("mid_hf",    32'(o2_hf),    32'd0);
        check("mid_ov",    32'(o2_ov),    32'd0);
        n_reset = 1'b1;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h3C);
        settle();
        check("mid_out_data",  32'(o2_data),  32'h3C);
        check("mid_out_level", 32'(o2_level), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
